// File: rtl/img_seq_pkg.sv
// img_xform_sequencer shared types: op codes, FSM states, default geometry.
// Imported by the sequencer top and its valid pipe.
package img_seq_pkg;

  localparam int unsigned IMG_W_DEF = 1024;
  localparam int unsigned IMG_H_DEF = 1024;
  localparam int unsigned PIX_DEF   = IMG_W_DEF * IMG_H_DEF;

  localparam logic [2:0] OP_STORE    = 3'b000;
  localparam logic [2:0] OP_ROT_CCW  = 3'b001;
  localparam logic [2:0] OP_ROT_CW   = 3'b010;
  localparam logic [2:0] OP_ROT_180  = 3'b011;
  localparam logic [2:0] OP_MIRROR_H = 3'b100;
  localparam logic [2:0] OP_MIRROR_V = 3'b101;
  localparam logic [2:0] OP_IDLE_RD  = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ARM,
    ST_XFORM,
    ST_DRAIN,
    ST_DONE
  } state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_MIRROR_V;
  endfunction

endpackage

// File: rtl/img_seq_valid_pipe.sv
// Delays the read-issue strobe and its last marker by the SRAM latency.
// Synchronous clear drops any in-flight beats.
module img_seq_valid_pipe
  import img_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic clr_i,
  input  logic vld_i,
  input  logic last_i,
  output logic vld_o,
  output logic last_o
);

  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] last_q;

  // shift issue/last strobes one stage per cycle
  always_ff @(posedge clk) begin
    if (clr_i) begin
      vld_q  <= '0;
      last_q <= '0;
    end else begin
      vld_q  <= DEPTH'({vld_q, vld_i});
      last_q <= DEPTH'({last_q, last_i});
    end
  end

  assign vld_o  = vld_q[DEPTH-1];
  assign last_o = last_q[DEPTH-1];

endmodule

// File: rtl/img_xform_sequencer.sv
// Frame sequencer: LOAD pass into SRAM, then oriented TRANSFORM read-out.
// Macro IMG_SEQ_REUSE_FRAME_EN enables skipping LOAD for a stored frame.
module img_xform_sequencer
  import img_seq_pkg::*;
#(
  parameter int unsigned IMG_W    = IMG_W_DEF,
  parameter int unsigned IMG_H    = IMG_H_DEF,
  parameter int unsigned READ_LAT = 1,
  parameter int unsigned CNT_W    = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic        cmd_reuse,
  input  logic        in_valid,
  input  logic [23:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [23:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic        err_illegal,
  output logic        err_underrun,
  output logic        ad_rst,
  output logic [2:0]  ad_op_mode,
  output logic [23:0] ad_data_in,
  input  logic [23:0] ad_data_out
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IMG_W * IMG_H - 1);
  localparam logic [CNT_W-1:0] RL_LAST  = CNT_W'(READ_LAT - 1);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frame_valid_q;
  logic             cmd_ready_q, in_ready_q, busy_q, done_q;
  logic             err_illegal_q, err_underrun_q;
  logic             ad_rst_q;
  logic [2:0]       ad_op_mode_q;
  logic             accept, legal, pass_end, drain_end;
  logic             issue, issue_last, pipe_vld, pipe_last;

  assign accept    = cmd_valid && cmd_ready_q;
  assign legal     = op_legal(cmd_op);
  assign pass_end  = cnt_q == LAST_CNT;
  assign drain_end = cnt_q == RL_LAST;

`ifndef IMG_SEQ_REUSE_FRAME_EN
  logic unused_reuse;
  assign unused_reuse = cmd_reuse ^ frame_valid_q;
`endif

  // next-state decode
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && legal) begin
          op_d    = cmd_op;
          state_d = ST_LOAD;
`ifdef IMG_SEQ_REUSE_FRAME_EN
          if (cmd_reuse && frame_valid_q)
            state_d = (cmd_op == OP_STORE) ? ST_DONE : ST_ARM;
`endif
        end
      end
      ST_LOAD: begin
        if (pass_end)
          state_d = (op_q == OP_STORE) ? ST_DONE : ST_ARM;
      end
      ST_ARM:   state_d = ST_XFORM;
      ST_XFORM: if (pass_end) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_end) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // pass counter restarts at every state change, idles at zero
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (state_d != state_q)
      cnt_d = '0;
    else if (!(state_q inside {ST_LOAD, ST_XFORM, ST_DRAIN}))
      cnt_d = '0;
  end

  // state, op and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_STORE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  // stored-frame validity and sticky underrun flag
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_valid_q  <= 1'b0;
      err_underrun_q <= 1'b0;
    end else begin
      if (state_q == ST_LOAD && pass_end)
        frame_valid_q <= 1'b1;
      else if (state_q == ST_IDLE && state_d == ST_LOAD)
        frame_valid_q <= 1'b0;
      if (accept && legal)
        err_underrun_q <= 1'b0;
      else if (state_q == ST_LOAD && !in_valid)
        err_underrun_q <= 1'b1;
    end
  end

  // registered control outputs decoded from the upcoming state
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_ready_q   <= 1'b0;
      in_ready_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_illegal_q <= 1'b0;
      ad_rst_q      <= 1'b1;
      ad_op_mode_q  <= OP_IDLE_RD;
    end else begin
      cmd_ready_q   <= state_d == ST_IDLE;
      in_ready_q    <= state_d == ST_LOAD;
      busy_q        <= state_d != ST_IDLE;
      done_q        <= state_d == ST_DONE;
      err_illegal_q <= accept && !legal;
      ad_rst_q      <= !(state_d inside {ST_LOAD, ST_XFORM});
      if (state_d == ST_LOAD)
        ad_op_mode_q <= OP_STORE;
      else if (state_d == ST_XFORM)
        ad_op_mode_q <= op_d;
      else
        ad_op_mode_q <= OP_IDLE_RD;
    end
  end

  assign issue      = state_q == ST_XFORM;
  assign issue_last = issue && pass_end;

  img_seq_valid_pipe #(
    .DEPTH (READ_LAT)
  ) u_pipe (
    .clk    (clk),
    .clr_i  (rst),
    .vld_i  (issue),
    .last_i (issue_last),
    .vld_o  (pipe_vld),
    .last_o (pipe_last)
  );

  assign cmd_ready    = cmd_ready_q;
  assign in_ready     = in_ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err_illegal  = err_illegal_q;
  assign err_underrun = err_underrun_q;
  assign ad_rst       = ad_rst_q;
  assign ad_op_mode   = ad_op_mode_q;
  assign ad_data_in   = in_data;
  assign out_valid    = pipe_vld;
  assign out_last     = pipe_last;
  assign out_data     = pipe_vld ? ad_data_out : '0;

endmodule

// File: tb/tb_img_xform_sequencer.sv
// Directed bench for img_xform_sequencer on a 4x4 frame, READ_LAT=1.
// Includes a behavioural adapter + SRAM; honours IMG_SEQ_REUSE_FRAME_EN.
module tb_img_xform_sequencer;

  localparam logic [23:0] BASE = 24'h0A0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op;
  logic        cmd_reuse;
  logic        in_valid;
  logic [23:0] in_data;
  logic        in_ready, out_valid, out_last;
  logic [23:0] out_data;
  logic        busy, done, err_illegal, err_underrun;
  logic        ad_rst;
  logic [2:0]  ad_op_mode;
  logic [23:0] ad_data_in, ad_data_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  img_xform_sequencer #(
    .IMG_W    (4),
    .IMG_H    (4),
    .READ_LAT (1),
    .CNT_W    (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_reuse    (cmd_reuse),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done),
    .err_illegal  (err_illegal),
    .err_underrun (err_underrun),
    .ad_rst       (ad_rst),
    .ad_op_mode   (ad_op_mode),
    .ad_data_in   (ad_data_in),
    .ad_data_out  (ad_data_out)
  );

  // behavioural adapter: free-running x,y and orientation address map
  logic [1:0]  ax, ay;
  logic [23:0] mem [16];
  int          wr_cnt = 0;

  function automatic logic [3:0] map_addr(input logic [2:0] m,
                                          input logic [1:0] x,
                                          input logic [1:0] y);
    case (m)
      3'b001:  return {x, 2'd3 - y};
      3'b010:  return {2'd3 - x, y};
      3'b011:  return {2'd3 - y, 2'd3 - x};
      3'b100:  return {y, 2'd3 - x};
      3'b101:  return {2'd3 - y, x};
      default: return {y, x};
    endcase
  endfunction

  always @(posedge clk) begin
    ad_data_out <= mem[map_addr(ad_op_mode, ax, ay)];
    if (!ad_rst && ad_op_mode == 3'b000) begin
      mem[map_addr(3'b000, ax, ay)] <= ad_data_in;
      wr_cnt++;
    end
    if (ad_rst) begin
      ax <= 2'd0;
      ay <= 2'd0;
    end else begin
      {ay, ax} <= {ay, ax} + 4'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // expected pixel of output beat k for a 4x4 frame loaded with BASE+i
  function automatic logic [23:0] exp_pix(input logic [2:0] op,
                                          input int k);
    int x, y;
    x = k % 4;
    y = k / 4;
    case (op)
      3'b011:  return BASE + 24'(15 - k);
      3'b001:  return BASE + 24'(x * 4 + 3 - y);
      3'b100:  return BASE + 24'(y * 4 + 3 - x);
      default: return BASE + 24'(k);
    endcase
  endfunction

  int          done_at, nb, nload, first_o, last_o, last_idx, nlast;
  logic        ur_done, ur_n1, busy_n1, cr_n1;
  logic [23:0] got [32];

  // issue one command and step until done, a planted reset or the budget
  task automatic run_cmd(input logic [2:0] op, input logic reuse,
                         input int drop_k, input int rst_at);
    @(negedge clk);
    cmd_op    = op;
    cmd_reuse = reuse;
    cmd_valid = 1'b1;
    done_at = -1; nb = 0; nload = 0; nlast = 0;
    first_o = -1; last_o = -1; last_idx = -1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      cmd_valid = (n == 1);
      if (n == 1) begin
        ur_n1   = err_underrun;
        busy_n1 = busy;
        cr_n1   = cmd_ready;
      end
      if (in_ready) begin
        in_valid = (nload != drop_k);
        in_data  = BASE + 24'(nload);
        nload++;
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) begin
        if (nb < 32) got[nb] = out_data;
        if (first_o < 0) first_o = n;
        last_o = n;
        if (out_last) begin
          nlast++;
          last_idx = nb;
        end
        nb++;
      end
      if (done) begin
        done_at = n;
        ur_done = err_underrun;
        break;
      end
      if (n == rst_at) begin
        rst = 1'b1;
        break;
      end
    end
    cmd_valid = 1'b0;
    in_valid  = 1'b0;
  endtask

  task automatic chk_full(input string tag, input logic [2:0] op);
    chk({tag, "_done_at"}, done_at, 35);
    chk({tag, "_beats"}, nb, 16);
    chk({tag, "_first"}, first_o, 19);
    chk({tag, "_lastbeat"}, last_o, 34);
    chk({tag, "_nlast"}, nlast, 1);
    chk({tag, "_last_idx"}, last_idx, 15);
    chk({tag, "_loads"}, nload, 16);
    chk({tag, "_busy"}, busy_n1, 1);
    chk({tag, "_cmd_ready_busy"}, cr_n1, 0);
    for (int k = 0; k < 16; k++)
      chk($sformatf("%s_px%0d", tag, k), got[k], exp_pix(op, k));
  endtask

  initial begin
    int wsnap;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'b000; cmd_reuse = 1'b0;
    in_valid = 1'b0; in_data = 24'h0;
    repeat (3) @(negedge clk);
    chk("rst_ad_rst", ad_rst, 1);
    chk("rst_ad_op_mode", ad_op_mode, 3'b111);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_err_underrun", err_underrun, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_cmd_ready", cmd_ready, 1);

    // rotate 180
    run_cmd(3'b011, 1'b0, -1, -1);
    chk_full("rot180", 3'b011);
    chk("rot180_underrun", ur_done, 0);
    @(negedge clk);
    chk("rot180_idle_ready", cmd_ready, 1);

    // rotate CCW; SRAM addr 0 must survive the read passes
    run_cmd(3'b001, 1'b0, -1, -1);
    chk_full("rotccw", 3'b001);
    repeat (3) @(negedge clk);
    chk("rotccw_mem0", mem[0], BASE);

    // illegal op
    wsnap = wr_cnt;
    cmd_op = 3'b110; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("ill_pulse", err_illegal, 1);
    chk("ill_busy", busy, 0);
    chk("ill_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    chk("ill_pulse_end", err_illegal, 0);
    chk("ill_busy2", busy, 0);
    chk("ill_no_write", wr_cnt, wsnap);

    // load-only with a dropped beat
    run_cmd(3'b000, 1'b0, 5, -1);
    chk("ur_done_at", done_at, 17);
    chk("ur_flag", ur_done, 1);
    chk("ur_beats", nb, 0);

    // reset at XFORM beat 7; underrun cleared on accept
    run_cmd(3'b011, 1'b0, -1, 25);
    chk("ur_cleared", ur_n1, 0);
    chk("abort_no_done", done_at, -1);
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_last", out_last, 0);
    chk("abort_out_data", out_data, 0);
    chk("abort_cmd_ready", cmd_ready, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_ad_rst", ad_rst, 1);
    chk("abort_ad_op_mode", ad_op_mode, 3'b111);
    rst = 1'b0;

    run_cmd(3'b011, 1'b0, -1, -1);
    chk_full("rerun", 3'b011);

    // reuse of stored frame
    run_cmd(3'b100, 1'b1, -1, -1);
    for (int k = 0; k < 16; k++)
      chk($sformatf("reuse_px%0d", k), got[k], exp_pix(3'b100, k));
    chk("reuse_nlast", nlast, 1);
`ifdef IMG_SEQ_REUSE_FRAME_EN
    chk("reuse_loads", nload, 0);
    chk("reuse_done_at", done_at, 19);
    run_cmd(3'b000, 1'b1, -1, -1);
    chk("reuse_store_done_at", done_at, 1);
`else
    chk("reuse_loads", nload, 16);
    chk("reuse_done_at", done_at, 35);
    run_cmd(3'b000, 1'b1, -1, -1);
    chk("reuse_store_done_at", done_at, 17);
`endif
    @(negedge clk);
    chk("end_done_low", done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/img_xform_sequencer.md
Name: img_xform_sequencer

Overview:
Sequences the image-transform adapter and its SRAM through a full frame operation. It accepts one command and runs a LOAD pass that streams IMG_W*IMG_H input pixels into SRAM in raster order. It then runs a TRANSFORM pass that reads the frame back in the commanded orientation and streams it out. It owns the adapter's reset and op_mode, because the adapter's coordinate counters free-run every cycle and must be realigned at each pass start.

Parameters:
IMG_W, 1024, image width in pixels (must match adapter)
IMG_H, 1024, image height in pixels (must match adapter)
READ_LAT, 1, SRAM read latency in cycles (1..4)
CNT_W, 20, pixel counter width, ceil(log2(IMG_W*IMG_H))

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_op  in  3  000 load-only, 001 rot CCW, 010 rot CW, 011 rot 180, 100 mirror H, 101 mirror V; 110/111 illegal
cmd_reuse  in  1  skip LOAD, reuse stored frame (see Optional Feature)
in_valid  in  1  input pixel valid
in_data  in  24  input RGB pixel
in_ready  out  1  high in LOAD
out_valid  out  1  output pixel valid (no backpressure)
out_data  out  24  output RGB pixel
out_last  out  1  with final output pixel
busy  out  1  state != IDLE
done  out  1  one-cycle pulse, operation complete
err_illegal  out  1  one-cycle pulse, illegal op rejected
err_underrun  out  1  sticky, in_valid low during LOAD
ad_rst  out  1  adapter reset (registered)
ad_op_mode  out  3  adapter op_mode
ad_data_in  out  24  = in_data
ad_data_out  in  24  adapter read data

Behaviour:
- Reset values: all outputs 0, except ad_rst=1 and ad_op_mode=3'b111. State becomes IDLE, counters 0, frame_valid=0, err_underrun=0.
- Reset mid-operation aborts immediately. No done pulse is issued, and the stored frame is considered invalid.
- ad_op_mode is 3'b000 only in LOAD. It is 3'b111 (read, we=0) in IDLE, ARM, DRAIN and DONE, so SRAM address 0 is never overwritten.
- States: IDLE, LOAD, ARM, XFORM, DRAIN, DONE.
- IDLE: ad_rst=1, cmd_ready=1.
  - Accept on cmd_valid&&cmd_ready at cycle T; latch op.
  - Illegal op: pulse err_illegal at T+1 and stay IDLE.
  - Legal op: clear err_underrun, go to LOAD.
- LOAD: ad_rst=0, in_ready=1. Pixel k is written at cycle T+1+k, for k=0..PIX-1 with PIX=IMG_W*IMG_H.
  - in_valid low in any LOAD cycle sets err_underrun; the write proceeds anyway because the adapter cannot stall.
  - At count PIX-1, set frame_valid. Go to DONE if op=000, else ARM.
- ARM: one cycle, ad_rst=1, which realigns adapter x,y to 0.
- XFORM: ad_rst=0, ad_op_mode=op, for PIX cycles. The first address is issued at T+PIX+2.
  - out_valid is the issue strobe delayed by READ_LAT through a shift register.
  - out_data = ad_data_out when out_valid.
  - out_last accompanies the PIX-th valid.
- DRAIN: READ_LAT cycles, ad_rst=1.
- DONE: done=1 for one cycle, ad_rst=1, then IDLE.
- Full-op latency: last out_valid at T+2*PIX+1+READ_LAT; done at T+2*PIX+2+READ_LAT.
- Load-only (op=000) latency: done at T+PIX+1.
- Counter: CNT_W bits, compared against PIX-1 for the pass end, never relies on wrap.
- cmd_valid outside IDLE is ignored (cmd_ready=0).

Optional Feature:
- Macro IMG_SEQ_REUSE_FRAME_EN.
- Defined: cmd_reuse=1 with frame_valid=1 and a non-000 op goes IDLE→ARM directly, skipping LOAD. done then comes at T+PIX+2+READ_LAT.
- Defined: cmd_reuse=1 with frame_valid=0 behaves as a normal command.
- Defined: cmd_reuse=1 with op=000 gives an immediate DONE.
- Undefined: cmd_reuse is ignored; LOAD always runs.

Decomposition:
- Package img_seq_pkg holds:
  - IMG_W/IMG_H defaults and PIX.
  - Op-code constants (OP_STORE..OP_MIRROR_V, OP_IDLE_RD=3'b111).
  - State encoding.
- One natural sub-module: img_seq_valid_pipe, a READ_LAT-deep valid/last shift register with synchronous clear.
- The FSM and counters stay in the top.

Test Plan:
- IMG_W=IMG_H=4 with a behavioural adapter+SRAM model; load pixels 0..15, op=011 → out_data 15..0, out_last on 16th beat, done at T+35 (READ_LAT=1).
- op=001 after load 0..15 → output order matches model address {x,3-y}; all 16 beats consecutive; SRAM addr 0 still holds 0 after completion.
- cmd_op=3'b110 → err_illegal pulse at T+1, busy stays 0, no SRAM write, cmd_ready high next cycle.
- in_valid dropped at LOAD beat 5 → err_underrun=1 through done; cleared on next accepted command.
- rst asserted at XFORM beat 7 → next cycle: all outputs 0, ad_rst=1, ad_op_mode=111, no done; new command runs normally.
- IMG_SEQ_REUSE_FRAME_EN defined: load, then cmd_reuse=1 op=100 → no in_ready, done at T+19, mirrored data; with macro undefined the same command re-enters LOAD.
